scoreboard_ctrl: RTL and testbench

SCOREBOARD_CTRL -- requirements
Module: scoreboard_ctrl

---
 rtl/scoreboard_ctrl.sv | 156 +++++++++++++++
 tb/tb_scoreboard_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_ctrl.sv
// In-order commit scoreboard: circular buffer of issued instructions with out-of-order writeback.
// Define SCOREBOARD_CTRL_FORWARD_EN to build the rs1 forwarding/busy lookup.
module scoreboard_ctrl #(
    parameter int NR_ENTRIES    = 4,
    parameter int NR_WB_PORTS   = 2,
    parameter int TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 flush_i,
    input  logic                                 issue_valid_i,
    input  logic [4:0]                           issue_rd_i,
    input  logic [3:0]                           issue_fu_i,
    output logic                                 issue_ready_o,
    output logic [TRANS_ID_BITS-1:0]             issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]               wb_valid_i,
    input  logic [NR_WB_PORTS*TRANS_ID_BITS-1:0] wb_trans_id_i,
    input  logic [NR_WB_PORTS*64-1:0]            wb_result_i,
    input  logic [NR_WB_PORTS-1:0]               wb_ex_valid_i,
    output logic                                 commit_valid_o,
    input  logic                                 commit_ack_i,
    output logic [4:0]                           commit_rd_o,
    output logic [63:0]                          commit_result_o,
    output logic [TRANS_ID_BITS-1:0]             commit_trans_id_o,
    output logic                                 commit_ex_valid_o,
    output logic [TRANS_ID_BITS:0]               count_o,
    input  logic [4:0]                           rs1_i,
    output logic                                 rs1_busy_o,
    output logic                                 rs1_fwd_valid_o,
    output logic [63:0]                          rs1_fwd_o
);

    localparam int IW = TRANS_ID_BITS;
    localparam int PW = TRANS_ID_BITS + 1;

    logic [PW-1:0]                  head_q, tail_q, count;
    logic [IW-1:0]                  head_idx, tail_idx;
    logic [NR_ENTRIES-1:0]          done_q, ex_valid_q;
    logic [NR_ENTRIES-1:0][4:0]     rd_q;
    logic [NR_ENTRIES-1:0][3:0]     fu_q;
    logic [NR_ENTRIES-1:0][63:0]    result_q;

    logic                           issue_fire, commit_fire;
    logic [NR_ENTRIES-1:0]          wb_set, wb_ex;
    logic [NR_ENTRIES-1:0][63:0]    wb_res;

    assign head_idx = head_q[IW-1:0];
    assign tail_idx = tail_q[IW-1:0];
    assign count    = tail_q - head_q;
    assign count_o  = count;

    assign issue_ready_o    = (count < PW'(NR_ENTRIES));
    assign issue_trans_id_o = tail_idx;
    assign issue_fire       = issue_valid_i && issue_ready_o && !flush_i;

    assign commit_valid_o    = (count != '0) && done_q[head_idx];
    assign commit_fire       = commit_valid_o && commit_ack_i && !flush_i;
    assign commit_rd_o       = commit_valid_o ? rd_q[head_idx]     : '0;
    assign commit_result_o   = commit_valid_o ? result_q[head_idx] : '0;
    assign commit_trans_id_o = commit_valid_o ? head_idx           : '0;
    assign commit_ex_valid_o = commit_valid_o && ex_valid_q[head_idx];

    // Highest port first so the lowest-index port overwrites on a collision.
    always_comb begin : wb_decode
        logic [IW-1:0] id;
        logic [IW-1:0] off;
        wb_set = '0;
        wb_ex  = '0;
        wb_res = '0;
        id     = '0;
        off    = '0;
        for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
            id  = wb_trans_id_i[p*IW +: IW];
            off = id - head_idx;
            if (wb_valid_i[p] && ({1'b0, off} < count)) begin
                wb_set[id] = 1'b1;
                wb_ex[id]  = wb_ex_valid_i[p];
                wb_res[id] = wb_result_i[p*64 +: 64];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            done_q     <= '0;
            ex_valid_q <= '0;
        end else if (flush_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            done_q     <= '0;
            ex_valid_q <= '0;
        end else begin
            for (int e = 0; e < NR_ENTRIES; e++) begin
                if (wb_set[e]) begin
                    done_q[e]     <= 1'b1;
                    ex_valid_q[e] <= wb_ex[e];
                end
            end
            // A freed head must not keep a same-cycle writeback's done bit.
            if (commit_fire) begin
                done_q[head_idx]     <= 1'b0;
                ex_valid_q[head_idx] <= 1'b0;
                head_q               <= head_q + PW'(1);
            end
            if (issue_fire) begin
                done_q[tail_idx]     <= 1'b0;
                ex_valid_q[tail_idx] <= 1'b0;
                tail_q               <= tail_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!flush_i) begin
            for (int e = 0; e < NR_ENTRIES; e++) begin
                if (wb_set[e])
                    result_q[e] <= wb_res[e];
            end
            if (issue_fire) begin
                rd_q[tail_idx] <= issue_rd_i;
                fu_q[tail_idx] <= issue_fu_i;
            end
        end
    end

    logic unused_fu;
    assign unused_fu = ^fu_q;

`ifdef SCOREBOARD_CTRL_FORWARD_EN
    // Oldest to youngest, so the youngest matching entry is the one left standing.
    always_comb begin : fwd_search
        logic [IW-1:0] idx;
        rs1_busy_o      = 1'b0;
        rs1_fwd_valid_o = 1'b0;
        rs1_fwd_o       = '0;
        idx             = '0;
        for (int k = 0; k < NR_ENTRIES; k++) begin
            idx = head_idx + IW'(k);
            if ((PW'(k) < count) && (rs1_i != 5'd0) && (rd_q[idx] == rs1_i)) begin
                rs1_busy_o      = !done_q[idx];
                rs1_fwd_valid_o = done_q[idx];
                rs1_fwd_o       = done_q[idx] ? result_q[idx] : '0;
            end
        end
    end
`else
    logic unused_rs1;
    assign unused_rs1      = ^rs1_i;
    assign rs1_busy_o      = 1'b0;
    assign rs1_fwd_valid_o = 1'b0;
    assign rs1_fwd_o       = '0;
`endif

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed bench for scoreboard_ctrl: fill, out-of-order writeback, collision, flush, wrap, forwarding, reset.
module tb_scoreboard_ctrl;

    localparam int N  = 4;
    localparam int P  = 2;
    localparam int IW = 2;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            flush_i;
    logic            issue_valid_i;
    logic [4:0]      issue_rd_i;
    logic [3:0]      issue_fu_i;
    logic            issue_ready_o;
    logic [IW-1:0]   issue_trans_id_o;
    logic [P-1:0]    wb_valid_i;
    logic [P*IW-1:0] wb_trans_id_i;
    logic [P*64-1:0] wb_result_i;
    logic [P-1:0]    wb_ex_valid_i;
    logic            commit_valid_o;
    logic            commit_ack_i;
    logic [4:0]      commit_rd_o;
    logic [63:0]     commit_result_o;
    logic [IW-1:0]   commit_trans_id_o;
    logic            commit_ex_valid_o;
    logic [IW:0]     count_o;
    logic [4:0]      rs1_i;
    logic            rs1_busy_o;
    logic            rs1_fwd_valid_o;
    logic [63:0]     rs1_fwd_o;

    int n_checks = 0;
    int n_fail   = 0;

    scoreboard_ctrl #(.NR_ENTRIES(N), .NR_WB_PORTS(P), .TRANS_ID_BITS(IW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .issue_fu_i(issue_fu_i),
        .issue_ready_o(issue_ready_o), .issue_trans_id_o(issue_trans_id_o),
        .wb_valid_i(wb_valid_i), .wb_trans_id_i(wb_trans_id_i),
        .wb_result_i(wb_result_i), .wb_ex_valid_i(wb_ex_valid_i),
        .commit_valid_o(commit_valid_o), .commit_ack_i(commit_ack_i),
        .commit_rd_o(commit_rd_o), .commit_result_o(commit_result_o),
        .commit_trans_id_o(commit_trans_id_o), .commit_ex_valid_o(commit_ex_valid_o),
        .count_o(count_o), .rs1_i(rs1_i), .rs1_busy_o(rs1_busy_o),
        .rs1_fwd_valid_o(rs1_fwd_valid_o), .rs1_fwd_o(rs1_fwd_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        flush_i       = 1'b0;
        issue_valid_i = 1'b0;
        issue_rd_i    = '0;
        issue_fu_i    = '0;
        wb_valid_i    = '0;
        wb_trans_id_i = '0;
        wb_result_i   = '0;
        wb_ex_valid_i = '0;
        commit_ack_i  = 1'b0;
        rs1_i         = '0;
    endtask

    task automatic wb(input int port, input int id, input logic [63:0] res, input logic ex);
        wb_valid_i[port]              = 1'b1;
        wb_trans_id_i[port*IW +: IW]  = IW'(id);
        wb_result_i[port*64 +: 64]    = res;
        wb_ex_valid_i[port]           = ex;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        idle();
        #3;
        chk("rst_count", count_o, 0);
        chk("rst_ready", issue_ready_o, 1);
        chk("rst_commit_valid", commit_valid_o, 0);
        chk("rst_commit_result", commit_result_o, 0);
        chk("rst_trans_id", issue_trans_id_o, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // fill to capacity, then a fifth issue must be refused
        for (int k = 0; k < 4; k++) begin
            issue_valid_i = 1'b1;
            issue_rd_i    = 5'(k + 1);
            issue_fu_i    = 4'(k);
            #1;
            chk("fill_id", issue_trans_id_o, k);
            tick();
        end
        chk("fill_count", count_o, 4);
        chk("fill_ready", issue_ready_o, 0);
        chk("fill_no_commit", commit_valid_o, 0);
        tick();
        chk("fifth_ignored", count_o, 4);

        // out-of-order writeback, in-order commit
        idle(); wb(0, 2, 64'h22, 1'b0); tick();
        idle(); wb(0, 0, 64'h100, 1'b1); tick();
        idle(); commit_ack_i = 1'b1; #1;
        chk("c0_valid", commit_valid_o, 1);
        chk("c0_id", commit_trans_id_o, 0);
        chk("c0_rd", commit_rd_o, 1);
        chk("c0_result", commit_result_o, 64'h100);
        chk("c0_ex", commit_ex_valid_o, 1);
        tick(); #1;
        chk("id1_blocks", commit_valid_o, 0);
        chk("id1_blocks_count", count_o, 3);
        chk("gated_result", commit_result_o, 0);
        wb(1, 1, 64'h11, 1'b0); tick();
        idle(); commit_ack_i = 1'b1; #1;
        chk("c1_id", commit_trans_id_o, 1);
        chk("c1_result", commit_result_o, 64'h11);
        chk("c1_rd", commit_rd_o, 2);
        tick(); #1;
        chk("c2_id", commit_trans_id_o, 2);
        chk("c2_result", commit_result_o, 64'h22);
        chk("c2_ex", commit_ex_valid_o, 0);
        tick(); #1;
        chk("after_c2_valid", commit_valid_o, 0);
        chk("after_c2_count", count_o, 1);

        // writeback to the entry being issued is dropped; port collision
        idle(); issue_valid_i = 1'b1; issue_rd_i = 5'd6; wb(0, 0, 64'hBAD, 1'b1); #1;
        chk("wrapid_0", issue_trans_id_o, 0);
        tick();
        idle(); issue_valid_i = 1'b1; issue_rd_i = 5'd7; #1;
        chk("wrapid_1", issue_trans_id_o, 1);
        tick();
        idle(); wb(0, 1, 64'hA, 1'b0); wb(1, 1, 64'hB, 1'b1); tick();
        idle(); wb(0, 3, 64'h33, 1'b0); tick();
        idle(); commit_ack_i = 1'b1; #1;
        chk("c3_id", commit_trans_id_o, 3);
        chk("c3_result", commit_result_o, 64'h33);
        chk("c3_rd", commit_rd_o, 4);
        tick(); #1;
        chk("issue_wb_ignored", commit_valid_o, 0);
        wb(1, 0, 64'h44, 1'b0); tick();
        idle(); commit_ack_i = 1'b1; wb(0, 0, 64'h55, 1'b1); #1;
        chk("c0b_result_old", commit_result_o, 64'h44);
        chk("c0b_rd", commit_rd_o, 6);
        tick();
        idle(); commit_ack_i = 1'b1; #1;
        chk("coll_id", commit_trans_id_o, 1);
        chk("coll_result", commit_result_o, 64'hA);
        chk("coll_ex", commit_ex_valid_o, 0);
        chk("coll_rd", commit_rd_o, 7);
        tick(); #1;
        chk("empty_count", count_o, 0);
        chk("empty_valid", commit_valid_o, 0);

        // flush with issue, commit and writeback all requested
        idle();
        for (int k = 0; k < 3; k++) begin
            issue_valid_i = 1'b1;
            issue_rd_i    = 5'(8 + k);
            tick();
        end
        idle(); wb(0, 2, 64'h77, 1'b0); tick();
        chk("pre_flush_valid", commit_valid_o, 1);
        chk("pre_flush_count", count_o, 3);
        flush_i = 1'b1; issue_valid_i = 1'b1; commit_ack_i = 1'b1; wb(1, 3, 64'h99, 1'b0);
        tick();
        idle(); #1;
        chk("flush_count", count_o, 0);
        chk("flush_valid", commit_valid_o, 0);
        chk("flush_ready", issue_ready_o, 1);
        chk("flush_next_id", issue_trans_id_o, 0);

        // steady issue+commit at count 1 across the pointer wrap
        issue_valid_i = 1'b1; issue_rd_i = 5'd12; #1;
        chk("wrap_issue_id", issue_trans_id_o, 0);
        tick();
        idle(); wb(0, 0, 64'h50, 1'b0); tick();
        for (int k = 1; k < 6; k++) begin
            idle(); issue_valid_i = 1'b1; issue_rd_i = 5'd12; commit_ack_i = 1'b1; #1;
            chk("wrap_issue_id", issue_trans_id_o, k % 4);
            chk("wrap_commit_id", commit_trans_id_o, (k - 1) % 4);
            chk("wrap_commit_result", commit_result_o, 64'h50 + 64'(k - 1));
            tick();
            chk("wrap_count", count_o, 1);
            idle(); wb(0, k % 4, 64'h50 + 64'(k), 1'b0); tick();
        end
        idle(); commit_ack_i = 1'b1; #1;
        chk("wrap_last_id", commit_trans_id_o, 1);
        chk("wrap_last_result", commit_result_o, 64'h55);
        tick(); #1;
        chk("wrap_final_count", count_o, 0);

        // forwarding: older rd=5 done, younger rd=5 pending
        idle(); issue_valid_i = 1'b1; issue_rd_i = 5'd5; tick();
        idle(); wb(0, 2, 64'h11, 1'b0); tick();
        idle(); issue_valid_i = 1'b1; issue_rd_i = 5'd5; tick();
        idle(); rs1_i = 5'd5; #1;
`ifdef SCOREBOARD_CTRL_FORWARD_EN
        chk("fwd_busy", rs1_busy_o, 1);
        chk("fwd_valid_pending", rs1_fwd_valid_o, 0);
        chk("fwd_data_pending", rs1_fwd_o, 0);
`else
        chk("fwd_off_busy", rs1_busy_o, 0);
        chk("fwd_off_valid", rs1_fwd_valid_o, 0);
        chk("fwd_off_data", rs1_fwd_o, 0);
`endif
        rs1_i = 5'd3; #1;
        chk("fwd_nomatch_busy", rs1_busy_o, 0);
        chk("fwd_nomatch_valid", rs1_fwd_valid_o, 0);
        chk("fwd_nomatch_data", rs1_fwd_o, 0);
        idle(); wb(0, 3, 64'h22, 1'b0); tick();
        idle(); rs1_i = 5'd5; #1;
`ifdef SCOREBOARD_CTRL_FORWARD_EN
        chk("fwd_done_busy", rs1_busy_o, 0);
        chk("fwd_done_valid", rs1_fwd_valid_o, 1);
        chk("fwd_done_data", rs1_fwd_o, 64'h22);
`else
        chk("fwd_off_done_valid", rs1_fwd_valid_o, 0);
        chk("fwd_off_done_data", rs1_fwd_o, 0);
`endif

        // reset mid-operation drops in-flight entries
        chk("pre_rst_count", count_o, 2);
        chk("pre_rst_valid", commit_valid_o, 1);
        #2 rst_i = 1'b1;
        #1;
        chk("midrst_count", count_o, 0);
        chk("midrst_valid", commit_valid_o, 0);
        chk("midrst_result", commit_result_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        chk("post_rst_count", count_o, 0);
        chk("post_rst_id", issue_trans_id_o, 0);
        chk("post_rst_ready", issue_ready_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
